// File: rtl/amq_host.sv
// Host-side wrapper for the AmQ core: gathers a 4-word operand block, serves it
// to AmQ while it runs, then reads back the 4-word result and streams it out.
module amq_host #(
  parameter int W  = 118,
  parameter int NW = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] IN_DATA,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [1:0]   AMQ_RD_INPUT_ADDR,
  output logic [W-1:0] AMQ_D_IN,
  output logic         AMQ_DATA_VALID,
  input  logic         AMQ_DONE,
  input  logic         AMQ_CENTRAL_L,
  output logic [1:0]   AMQ_RD_RES_ADDR,
  input  logic [W-1:0] AMQ_D_OUT,
  output logic [W-1:0] OUT_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         OUT_LAST,
  output logic         CENTRAL_FLAG,
  output logic         BUSY
);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] SEND  = 2'd3;

  logic [1:0]   state;
  logic [1:0]   wcnt, rcnt;
  logic [2:0]   fcnt;
  logic [W-1:0] op_buf  [NW];
  logic [W-1:0] res_buf [NW];

  logic in_acc, out_acc, fetch_addr_ph, fetch_cap_ph;

  assign in_acc        = (state == LOAD) && IN_VALID;
  assign out_acc       = (state == SEND) && OUT_READY;
  assign fetch_addr_ph = (state == FETCH) && (fcnt != 3'd4);
  assign fetch_cap_ph  = (state == FETCH) && (fcnt != 3'd0);

  assign IN_READY        = (state == LOAD);
  assign BUSY            = (state != LOAD);
  assign AMQ_D_IN        = op_buf[AMQ_RD_INPUT_ADDR];
  assign AMQ_RD_RES_ADDR = fetch_addr_ph ? fcnt[1:0] : 2'd0;
  assign OUT_VALID       = (state == SEND);
  assign OUT_DATA        = res_buf[rcnt];
  assign OUT_LAST        = (state == SEND) && (rcnt == 2'd3);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= LOAD;
      wcnt           <= 2'd0;
      rcnt           <= 2'd0;
      fcnt           <= 3'd0;
      AMQ_DATA_VALID <= 1'b0;
      CENTRAL_FLAG   <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_acc) begin
          wcnt <= wcnt + 2'd1;
          if (wcnt == 2'd3) begin
            state          <= RUN;
            AMQ_DATA_VALID <= 1'b1;
            CENTRAL_FLAG   <= 1'b0;
          end
        end
        RUN: begin
          // The DONE cycle's CENTRAL_L is still part of this operation.
          if (AMQ_CENTRAL_L) CENTRAL_FLAG <= 1'b1;
          if (AMQ_DONE) begin
            state          <= FETCH;
            AMQ_DATA_VALID <= 1'b0;
            fcnt           <= 3'd0;
          end
        end
        FETCH: begin
          if (fcnt == 3'd4) begin
            state <= SEND;
            fcnt  <= 3'd0;
          end else begin
            fcnt <= fcnt + 3'd1;
          end
        end
        SEND: if (out_acc) begin
          rcnt <= rcnt + 2'd1;
          if (rcnt == 2'd3) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Data buffers carry no reset; the FSM guarantees they are rewritten before use.
  always_ff @(posedge CLK) begin
    if (in_acc) op_buf[wcnt] <= IN_DATA;
    if (fetch_cap_ph) res_buf[fcnt[1:0] - 2'd1] <= AMQ_D_OUT;
  end

endmodule

// File: tb/tb_amq_host.sv
// Directed bench for amq_host: AmQ behavioural model plus a result scoreboard.
module tb_amq_host;
  localparam int W = 118;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] IN_DATA;
  logic         IN_VALID;
  logic         IN_READY;
  logic [1:0]   AMQ_RD_INPUT_ADDR;
  logic [W-1:0] AMQ_D_IN;
  logic         AMQ_DATA_VALID;
  logic         AMQ_DONE;
  logic         AMQ_CENTRAL_L;
  logic [1:0]   AMQ_RD_RES_ADDR;
  logic [W-1:0] AMQ_D_OUT;
  logic [W-1:0] OUT_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         OUT_LAST;
  logic         CENTRAL_FLAG;
  logic         BUSY;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] res_base = '0;
  logic [W-1:0] q[$];

  amq_host #(.W(W), .NW(4)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .AMQ_RD_INPUT_ADDR(AMQ_RD_INPUT_ADDR), .AMQ_D_IN(AMQ_D_IN),
    .AMQ_DATA_VALID(AMQ_DATA_VALID), .AMQ_DONE(AMQ_DONE),
    .AMQ_CENTRAL_L(AMQ_CENTRAL_L), .AMQ_RD_RES_ADDR(AMQ_RD_RES_ADDR),
    .AMQ_D_OUT(AMQ_D_OUT), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .CENTRAL_FLAG(CENTRAL_FLAG),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // AmQ result RAM: one-cycle read latency, contents res_base+addr.
  always @(posedge CLK) AMQ_D_OUT <= res_base + W'(AMQ_RD_RES_ADDR);

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_op(input logic [W-1:0] base, input bit hold, input logic [W-1:0] nb);
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = base + W'(i);
      chk("load_ready", W'(IN_READY), 1);
      tick();
    end
    if (hold) IN_DATA = nb;
    else IN_VALID = 1'b0;
    chk("run_dv", W'(AMQ_DATA_VALID), 1);
    chk("run_busy", W'(BUSY), 1);
    chk("run_in_ready", W'(IN_READY), 0);
    chk("run_flag_clr", W'(CENTRAL_FLAG), 0);
    for (int a = 0; a < 4; a++) begin
      AMQ_RD_INPUT_ADDR = 2'(a);
      #1;
      chk("amq_d_in", AMQ_D_IN, base + W'(a));
    end
  endtask

  task automatic run_amq(input int n, input bit cp, input logic [W-1:0] rb);
    res_base = rb;
    for (int i = 0; i < n; i++) begin
      if (cp && i == 3) AMQ_CENTRAL_L = 1'b1;
      tick();
      AMQ_CENTRAL_L = 1'b0;
      chk("run_hold_dv", W'(AMQ_DATA_VALID), 1);
      if (cp && i == 3) chk("central_set", W'(CENTRAL_FLAG), 1);
    end
    AMQ_DONE = 1'b1;
    tick();
    AMQ_DONE = 1'b0;
    chk("done_dv_clr", W'(AMQ_DATA_VALID), 0);
    chk("fetch_busy", W'(BUSY), 1);
    chk("fetch_addr0", W'(AMQ_RD_RES_ADDR), 0);
    chk("fetch_no_out", W'(OUT_VALID), 0);
  endtask

  task automatic drain(input logic [W-1:0] rb, input bit toggle, input bit exp_flag);
    int guard = 0;
    int got = 0;
    int k = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) q.push_back(rb + W'(i));
    tick();
    chk("fetch_addr1", W'(AMQ_RD_RES_ADDR), 1);
    guard = 1;
    while (!OUT_VALID && guard < 10) begin
      tick();
      guard++;
    end
    chk("fetch_len", W'(guard), 5);
    while (got < 4 && k < 40) begin
      OUT_READY = toggle ? pat[k % 4] : 1'b1;
      #1;
      chk("send_valid", W'(OUT_VALID), 1);
      chk("send_last", W'(OUT_LAST), W'(q.size() == 1));
      chk("send_flag", W'(CENTRAL_FLAG), W'(exp_flag));
      if (OUT_READY) begin
        chk("send_data", OUT_DATA, q.pop_front());
        got++;
      end else begin
        chk("stall_data", OUT_DATA, q[0]);
      end
      tick();
      k++;
    end
    OUT_READY = 1'b0;
    chk("send_count", W'(got), 4);
    chk("post_valid", W'(OUT_VALID), 0);
    chk("post_busy", W'(BUSY), 0);
    chk("post_in_ready", W'(IN_READY), 1);
  endtask

  initial begin
    RST = 1'b0; IN_DATA = '0; IN_VALID = 1'b0; AMQ_RD_INPUT_ADDR = 2'd0;
    AMQ_DONE = 1'b0; AMQ_CENTRAL_L = 1'b0; OUT_READY = 1'b0;
    #3;
    chk("rst_in_ready", W'(IN_READY), 1);
    chk("rst_busy", W'(BUSY), 0);
    chk("rst_out_valid", W'(OUT_VALID), 0);
    chk("rst_out_last", W'(OUT_LAST), 0);
    chk("rst_dv", W'(AMQ_DATA_VALID), 0);
    chk("rst_flag", W'(CENTRAL_FLAG), 0);
    chk("rst_res_addr", W'(AMQ_RD_RES_ADDR), 0);
    tick(); tick();
    RST = 1'b1;
    tick();
    chk("post_rst_ready", W'(IN_READY), 1);

    // DONE while idle must be ignored.
    AMQ_DONE = 1'b1;
    repeat (3) tick();
    chk("done_idle_ready", W'(IN_READY), 1);
    chk("done_idle_busy", W'(BUSY), 0);
    AMQ_DONE = 1'b0;

    load_op(W'(1), 1'b0, '0);
    run_amq(20, 1'b0, W'('hA0));
    drain(W'('hA0), 1'b0, 1'b0);

    load_op(W'('h10), 1'b0, '0);
    run_amq(20, 1'b1, W'('hB0));
    drain(W'('hB0), 1'b1, 1'b1);

    // Next operand held on IN during the whole op: must stall, then land first.
    load_op(W'('h20), 1'b1, W'('h30));
    run_amq(12, 1'b0, W'('hC0));
    drain(W'('hC0), 1'b1, 1'b0);

    load_op(W'('h30), 1'b0, '0);
    run_amq(5, 1'b1, W'('hE0));
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("abort_out_valid", W'(OUT_VALID), 0);
    chk("abort_busy", W'(BUSY), 0);
    chk("abort_dv", W'(AMQ_DATA_VALID), 0);
    chk("abort_flag", W'(CENTRAL_FLAG), 0);
    chk("abort_res_addr", W'(AMQ_RD_RES_ADDR), 0);
    chk("abort_in_ready", W'(IN_READY), 1);
    tick();
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_out", W'(OUT_VALID), 0);
    end

    load_op(W'('h40), 1'b0, '0);
    run_amq(20, 1'b0, W'('hD0));
    drain(W'('hD0), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/amq_host.md
AMQ_HOST -- requirements
Module: amq_host

Interface
REQ-001 SHALL have parameter W, default 118, the data word width of the AmQ input and result words.
REQ-002 SHALL have parameter NW, default 4, the words per operand/result block; it is fixed at 4 (2-bit addresses).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1, the reset; asynchronous and active-low.
REQ-005 SHALL have port IN_DATA, input, W, the upstream operand word.
REQ-006 SHALL have port IN_VALID, input, 1, qualifying IN_DATA.
REQ-007 SHALL have port IN_READY, output, 1, set when the block accepts an operand word this cycle.
REQ-008 SHALL have port AMQ_RD_INPUT_ADDR, input, 2, the AmQ input word address request.
REQ-009 SHALL have port AMQ_D_IN, output, W, the operand word served to AmQ.
REQ-010 SHALL have port AMQ_DATA_VALID, output, 1, asserting that the operand block is available to AmQ.
REQ-011 SHALL have port AMQ_DONE, input, 1, the AmQ completion signal.
REQ-012 SHALL have port AMQ_CENTRAL_L, input, 1, the AmQ CENTRAL_L_HAPPENED indication.
REQ-013 SHALL have port AMQ_RD_RES_ADDR, output, 2, the AmQ result word address.
REQ-014 SHALL have port AMQ_D_OUT, input, W, the AmQ result word, valid one cycle after AMQ_RD_RES_ADDR.
REQ-015 SHALL have port OUT_DATA, output, W, the result word to downstream.
REQ-016 SHALL have port OUT_VALID, output, 1, qualifying OUT_DATA.
REQ-017 SHALL have port OUT_READY, input, 1, the downstream acceptance.
REQ-018 SHALL have port OUT_LAST, output, 1, marking the 4th result word of a block.
REQ-019 SHALL have port CENTRAL_FLAG, output, 1, a sticky CENTRAL_L capture for the current operation.
REQ-020 SHALL have port BUSY, output, 1, high in every state except LOAD.

Function
REQ-021 SHALL implement the FSM states LOAD, RUN, FETCH, SEND.
REQ-022 In LOAD, IN_READY SHALL be 1; each IN_VALID&IN_READY cycle SHALL write IN_DATA to op_buf[wcnt] and increment the 2-bit wcnt.
REQ-023 On the accept with wcnt==3, the FSM SHALL go LOAD->RUN, wcnt SHALL wrap to 0, and CENTRAL_FLAG SHALL clear.
REQ-024 In RUN, AMQ_DATA_VALID SHALL be 1 (registered, asserted the first RUN cycle); IN_READY SHALL be 0 in all non-LOAD states.
REQ-025 AMQ_D_IN SHALL equal op_buf[AMQ_RD_INPUT_ADDR] combinationally (zero latency) in all states; op_buf SHALL be unchanged outside LOAD.
REQ-026 In RUN, AMQ_CENTRAL_L==1 in any cycle SHALL set CENTRAL_FLAG, which holds until the next LOAD->RUN transition.
REQ-027 In RUN, AMQ_DONE==1 SHALL cause RUN->FETCH next cycle, with AMQ_DATA_VALID deasserted in that same transition; AMQ_CENTRAL_L sampled in the DONE cycle SHALL also be captured.
REQ-028 AMQ_DONE SHALL be ignored outside RUN.
REQ-029 FETCH SHALL be 5 cycles: cycles 0..3 drive AMQ_RD_RES_ADDR=0..3; cycles 1..4 capture AMQ_D_OUT into res_buf[addr-1]; then FETCH->SEND.
REQ-030 AMQ_RD_RES_ADDR SHALL be 0 outside FETCH cycles 0..3.
REQ-031 In SEND, OUT_VALID SHALL be 1 and OUT_DATA SHALL be res_buf[rcnt].
REQ-032 In SEND, OUT_LAST SHALL be (rcnt==3).
REQ-033 On each OUT_VALID&OUT_READY, rcnt SHALL increment; on the handshake with rcnt==3, the FSM SHALL go SEND->LOAD and rcnt SHALL wrap to 0.
REQ-034 OUT_DATA/OUT_LAST SHALL hold stable while OUT_VALID&!OUT_READY (backpressure of any length).
REQ-035 Back-to-back operation: LOAD SHALL accept a new word the cycle after the final SEND handshake.
REQ-036 A new IN_VALID during RUN/FETCH/SEND SHALL be stalled, never dropped or overwritten.

Reset
REQ-037 RST low SHALL asynchronously force: state=LOAD, wcnt=rcnt=0, AMQ_DATA_VALID=0, OUT_VALID=0, OUT_LAST=0, CENTRAL_FLAG=0, AMQ_RD_RES_ADDR=0, BUSY=0.
REQ-038 op_buf/res_buf are not reset; OUT_DATA and AMQ_D_IN are don't-care until written.
REQ-039 Reset asserted mid-operation (any state) SHALL abort it; partially loaded or fetched words SHALL be discarded and no OUT_VALID SHALL follow.
REQ-040 IN_READY SHALL be 1 in the first cycle after RST deasserts.

Verification
REQ-041 Load 4 words 0x1..0x4 with IN_VALID held -> AMQ_DATA_VALID=1 on the cycle after the 4th accept; RD_INPUT_ADDR=2 -> AMQ_D_IN=0x3.
REQ-042 AmQ model asserts DONE after 20 cycles, D_OUT=0xA0+addr -> OUT stream 0xA0,0xA1,0xA2,0xA3 with OUT_LAST only on 0xA3.
REQ-043 OUT_READY toggling 1,0,0,1,... -> no word duplicated or lost, and OUT_DATA stable while stalled.
REQ-044 AMQ_CENTRAL_L pulsed 1 cycle in RUN -> CENTRAL_FLAG=1 through SEND, cleared at the next RUN entry.
REQ-045 RST low during FETCH cycle 2 -> all outputs at reset values; the next full operation produces correct results.
REQ-046 AMQ_DONE=1 while in LOAD -> no state change, IN_READY stays 1.
